// File: rtl/rx_packet_deframer_pkg.sv
// Shared types and constants for the RX packet deframer.
package rx_packet_deframer_pkg;

  // Width of the LEN field. It is also the width of a payload byte.
  localparam int unsigned LEN_W = 8;

  // Default frame start marker.
  localparam logic [LEN_W-1:0] SYNC_BYTE_DEFAULT = 8'h7E;

  // Deframer states.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } deframer_state_e;

endpackage

// File: rtl/rx_packet_deframer_byte_gap_timer.sv
// Inter-byte gap timer: a saturating up-counter with clear and enable inputs.
// limit is high while the count equals TIMEOUT_CYCLES.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic limit
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] count;

  // Clear has priority. When enabled the count rises by one and holds at LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign limit = (count == LIMIT);

endmodule

// File: rtl/rx_packet_deframer.sv
// Extracts SYNC, LEN, payload, CHK frames from the UART RX FIFO. The FIFO is
// first-word-fall-through. Payload bytes are streamed out on a valid/ready
// interface, and a one-cycle verdict pulse follows each frame.
//
// state   | meaning
// --------+----------------------------------------------------------
// HUNT    | discard bytes until SYNC_BYTE is popped
// LEN     | wait for the length byte; a repeated SYNC resyncs here
// PAYLOAD | forward FIFO head downstream, pop on outReady
// CHECK   | pop checksum byte, emit frameGood / frameBad
//
// The checksum covers LEN and all payload bytes. A frame is good when
// LEN + payload + CHK == 0 (mod 256). SYNC_BYTE has no special meaning
// inside the payload.
module rx_packet_deframer
  import rx_packet_deframer_pkg::*;
#(
  parameter logic [LEN_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned      MAX_LEN        = 64,
  parameter int unsigned      TIMEOUT_W      = 16,
  parameter int unsigned      TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] rxData,
  input  logic             rxDataPresent,
  output logic             rxRead,
  output logic [LEN_W-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             outLast,
  output logic             frameGood,
  output logic             frameBad,
  output logic             errLength,
  output logic             errTimeout,
  output logic             busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_B = LEN_W'(MAX_LEN);

  deframer_state_e  state;
  logic [LEN_W-1:0] sum;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] sum_add;
  logic             gap_limit;
  logic             gap_clr;
  logic             gap_en;

  // FIFO pop and payload handshake, decoded from the state and the FIFO head.
  // Everything is held low while reset is asserted, so no byte is consumed.
  always_comb begin
    rxRead   = 1'b0;
    outValid = 1'b0;
    outLast  = 1'b0;
    if (!rst) begin
      unique case (state)
        HUNT, LEN, CHECK: rxRead = rxDataPresent;
        PAYLOAD: begin
          outValid = rxDataPresent;
          outLast  = (remaining == LEN_W'(1));
          rxRead   = rxDataPresent & outReady;
        end
        default: rxRead = 1'b0;
      endcase
    end
  end

  assign outData = rxData;
  assign busy    = (state != HUNT);
  assign sum_add = sum + rxData;

  // Gap timer: it runs only while mid-frame and the FIFO is empty. A full
  // FIFO stalled by outReady never counts toward the timeout.
  assign gap_clr = (state == HUNT) | rxRead;
  assign gap_en  = (state != HUNT) & ~rxDataPresent;

  byte_gap_timer #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (gap_clr),
    .en    (gap_en),
    .limit (gap_limit)
  );

  // Frame state machine. The verdict and error pulses are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      sum        <= '0;
      remaining  <= '0;
      frameGood  <= 1'b0;
      frameBad   <= 1'b0;
      errLength  <= 1'b0;
      errTimeout <= 1'b0;
    end else begin
      frameGood  <= 1'b0;
      frameBad   <= 1'b0;
      errLength  <= 1'b0;
      errTimeout <= 1'b0;

      unique case (state)
        HUNT: begin
          if (rxRead && (rxData == SYNC_BYTE)) begin
            sum   <= '0;
            state <= LEN;
          end
        end

        LEN: begin
          if (rxRead) begin
            if (rxData == SYNC_BYTE) begin
              sum <= '0;
            end else if ((rxData == '0) || (rxData > MAX_LEN_B)) begin
              errLength <= 1'b1;
              state     <= HUNT;
            end else begin
              remaining <= rxData;
              sum       <= rxData;
              state     <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (rxRead) begin
            sum       <= sum_add;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (rxRead) begin
            if (sum_add == '0) begin
              frameGood <= 1'b1;
            end else begin
              frameBad <= 1'b1;
            end
            state <= HUNT;
          end
        end

        default: state <= HUNT;
      endcase

      // A byte consumed in the same cycle the limit is reached wins over
      // the timeout. rxRead is zero here, so no other pulse can collide.
      if ((state != HUNT) && gap_limit && !rxRead) begin
        errTimeout <= 1'b1;
        state      <= HUNT;
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Directed bench for rx_packet_deframer. A queue models the FWFT RX FIFO.
// Inputs change 1 ns after the rising edge and outputs are sampled on the
// falling edge.
module tb_rx_packet_deframer;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDataPresent;
  logic       rxRead;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       outLast;
  logic       frameGood;
  logic       frameBad;
  logic       errLength;
  logic       errTimeout;
  logic       busy;

  always #5 clk = ~clk;

  rx_packet_deframer #(
    .SYNC_BYTE      (8'h7E),
    .MAX_LEN        (64),
    .TIMEOUT_W      (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxData        (rxData),
    .rxDataPresent (rxDataPresent),
    .rxRead        (rxRead),
    .outData       (outData),
    .outValid      (outValid),
    .outReady      (outReady),
    .outLast       (outLast),
    .frameGood     (frameGood),
    .frameBad      (frameBad),
    .errLength     (errLength),
    .errTimeout    (errTimeout),
    .busy          (busy)
  );

  logic [7:0] fifo[$];
  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_cyc[$];
  int         n_good, n_bad, n_len, n_to;
  int         good_cyc, to_cyc, last_pop_cyc, cyc;
  int         stall_reads;
  logic       obs_read, obs_valid, obs_busy, obs_pulse;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    rxDataPresent = (fifo.size() != 0);
    rxData        = rxDataPresent ? fifo[0] : 8'h00;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    n_good = 0; n_bad = 0; n_len = 0; n_to = 0;
    good_cyc = -1; to_cyc = -1; last_pop_cyc = -1;
  endtask

  // One clock: observe at negedge, then pop the FIFO model if rxRead was high.
  task automatic cycle();
    logic rd;
    @(negedge clk);
    rd        = rxRead;
    obs_read  = rxRead;
    obs_valid = outValid;
    obs_busy  = busy;
    obs_pulse = frameGood | frameBad | errLength | errTimeout;
    if (outValid && outReady) begin
      got_data.push_back(outData);
      got_last.push_back(outLast);
      got_cyc.push_back(cyc);
    end
    if (frameGood)  begin n_good++; good_cyc = cyc; end
    if (frameBad)   n_bad++;
    if (errLength)  n_len++;
    if (errTimeout) begin n_to++; to_cyc = cyc; end
    if (rd) last_pop_cyc = cyc;
    cyc++;
    @(posedge clk);
    #1;
    if (rd && fifo.size() != 0) fifo.delete(0);
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic check_payload(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, got_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_data.size(); i++) begin
      check({tag, "_data"}, got_data[i], exp[i]);
      check({tag, "_last"}, got_last[i], (i == exp.size() - 1));
    end
  endtask

  initial begin
    logic [7:0] e[$];
    cyc = 0;
    clear_log();

    // Reset: nothing may be popped even with data waiting.
    rst = 1'b1; outReady = 1'b1;
    fifo = {8'h7E};
    drive_fifo();
    run(3);
    check("rst_rxRead", obs_read, 0);
    check("rst_outValid", obs_valid, 0);
    check("rst_pulse", obs_pulse, 0);
    rst = 1'b0;
    fifo.delete();
    drive_fifo();
    cycle();
    check("idle_busy", obs_busy, 0);

    // Good frame: 03 + 11 + 22 + 33 + 97 = 0x100.
    clear_log();
    fifo = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    drive_fifo();
    run(10);
    e = {8'h11, 8'h22, 8'h33};
    check_payload("good", e);
    if (got_cyc.size() == 3) check("good_b2b", got_cyc[2] - got_cyc[0], 2);
    check("good_nGood", n_good, 1);
    check("good_nBad", n_bad, 0);
    check("good_pulse_lat", good_cyc - last_pop_cyc, 1);
    check("good_busy", obs_busy, 0);

    // Bad checksum: the payload is still delivered.
    clear_log();
    fifo = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    drive_fifo();
    run(10);
    check_payload("bad", e);
    check("bad_nBad", n_bad, 1);
    check("bad_nGood", n_good, 0);

    // Junk byte, SYNC resync in LEN, zero length.
    clear_log();
    fifo = {8'h55, 8'h7E, 8'h7E, 8'h00};
    drive_fifo();
    run(8);
    check("len0_nLen", n_len, 1);
    check("len0_out", got_data.size(), 0);
    check("len0_verdict", n_good + n_bad, 0);
    check("len0_busy", obs_busy, 0);

    // Length one above the maximum.
    clear_log();
    fifo = {8'h7E, 8'h41};
    drive_fifo();
    run(5);
    check("lenmax_nLen", n_len, 1);
    check("lenmax_busy", obs_busy, 0);

    // Gap timeout mid-payload, then a clean frame: 01 + 05 + FA = 0x100.
    clear_log();
    fifo = {8'h7E, 8'h02, 8'hAA};
    drive_fifo();
    run(3 + TO + 5);
    check("to_nTo", n_to, 1);
    check("to_lat", to_cyc - last_pop_cyc, TO + 2);
    check("to_verdict", n_good + n_bad, 0);
    check("to_busy", obs_busy, 0);
    clear_log();
    fifo = {8'h7E, 8'h01, 8'h05, 8'hFA};
    drive_fifo();
    run(8);
    e = {8'h05};
    check_payload("post_to", e);
    check("post_to_nGood", n_good, 1);

    // Backpressure longer than the timeout: 02 + 10 + 20 + CE = 0x100.
    clear_log();
    fifo = {8'h7E, 8'h02, 8'h10, 8'h20, 8'hCE};
    drive_fifo();
    run(3);
    outReady = 1'b0;
    stall_reads = 0;
    repeat (TO + 10) begin
      cycle();
      if (obs_read) stall_reads++;
    end
    check("stall_reads", stall_reads, 0);
    check("stall_valid", obs_valid, 1);
    outReady = 1'b1;
    run(6);
    e = {8'h10, 8'h20};
    check_payload("stall", e);
    check("stall_nGood", n_good, 1);
    check("stall_nTo", n_to, 0);

    // Reset mid-payload drops the frame silently.
    clear_log();
    fifo = {8'h7E, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    drive_fifo();
    run(3);
    rst = 1'b1;
    cycle();
    check("midrst_rxRead", obs_read, 0);
    check("midrst_outValid", obs_valid, 0);
    rst = 1'b0;
    fifo.delete();
    drive_fifo();
    clear_log();
    run(4);
    check("midrst_busy", obs_busy, 0);
    check("midrst_pulses", n_good + n_bad + n_len + n_to, 0);
    check("midrst_out", got_data.size(), 0);

    // SYNC inside the payload is data: 02 + 7E + 01 + 7F = 0x100.
    clear_log();
    fifo = {8'h7E, 8'h02, 8'h7E, 8'h01, 8'h7F};
    drive_fifo();
    run(8);
    e = {8'h7E, 8'h01};
    check_payload("syncdata", e);
    check("syncdata_nGood", n_good, 1);
    check("syncdata_nBad", n_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
